// File: rtl/sdram_pixel_reader_pkg.sv
// Shared video definitions: packed-word bit fields common to the writer-side packer
// and this reader, plus the reader state encoding.
package sdram_pixel_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } rd_state_t;

  localparam int PIX_W = 30;

  // FIFO 2 word: {0, G[4:0], R[9:0]}
  localparam int R_LSB   = 0;
  localparam int R_MSB   = 9;
  localparam int GLO_LSB = 10;
  localparam int GLO_MSB = 14;
  // FIFO 1 word: {0, G[9:5], B[9:0]}
  localparam int GHI_LSB = 10;
  localparam int GHI_MSB = 14;
  localparam int B_LSB   = 0;
  localparam int B_MSB   = 9;

  // Returns {R[9:0], G[9:0], B[9:0]}; bit 15 of both words is ignored.
  function automatic logic [PIX_W-1:0] unpack_pixel(input logic [15:0] w1,
                                                    input logic [15:0] w2);
    return {w2[R_MSB:R_LSB], w1[GHI_MSB:GHI_LSB], w2[GLO_MSB:GLO_LSB], w1[B_MSB:B_LSB]};
  endfunction

endpackage

// File: rtl/sdram_pixel_reader_skid.sv
// Two-entry pixel buffer between the SDRAM read FIFOs and the display request.
// o_data is always the oldest entry; a push and pop at occupancy 1 keeps only the new word.
module pixel_skid_buf2
  import sdram_pixel_reader_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [PIX_W-1:0] i_data,
  output logic [PIX_W-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [PIX_W-1:0] r_head;
  logic [PIX_W-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_data  = r_head;
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else if (r_count == 2'd1) r_tail <= i_data;
          if (r_count != 2'd2) r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_pixel_reader.sv
// Display-side reader: prefetches packed words from two SDRAM read FIFOs into a
// 2-entry RGB buffer and answers one pixel per display request, flagging underflows.
module sdram_pixel_reader
  import sdram_pixel_reader_pkg::*;
#(
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 19
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iFrame_start,
  input  logic        iReq,
  input  logic        iRd1_empty,
  input  logic        iRd2_empty,
  input  logic [15:0] iRd1_data,
  input  logic [15:0] iRd2_data,
  output logic        oRd,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oValid,
  output logic        oUnderflow,
  output logic [15:0] oUnderflow_cnt,
  output logic        oFrame_short,
  output logic [1:0]  oDbg_state
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  rd_state_t        r_state;
  logic [CNT_W-1:0] r_px_cnt;
  logic             r_inflight;

  logic [PIX_W-1:0] w_head;
  logic [PIX_W-1:0] w_rd_pix;
  logic [1:0]       w_count;
  logic [2:0]       w_occ_after;
  logic             w_active;
  logic             w_restart;
  logic             w_stream_req;
  logic             w_pop;
  logic             w_push;
  logic             w_rd;

  assign w_active     = (r_state != ST_IDLE);
  assign w_restart    = iFrame_start && w_active;
  assign w_stream_req = iReq && (r_state == ST_STREAM) && !iFrame_start;
  assign w_pop        = w_stream_req && (w_count != 2'd0);
  // A word returning on a restart cycle belongs to the abandoned frame.
  assign w_push       = r_inflight && !w_restart;
  assign w_occ_after  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd         = w_active && !iFrame_start && !iRd1_empty && !iRd2_empty &&
                        (w_occ_after < 3'd2);
  assign w_rd_pix     = unpack_pixel(iRd1_data, iRd2_data);

  assign oRd        = w_rd;
  assign oDbg_state = r_state;

  pixel_skid_buf2 u_buf (
    .i_clk   (iClk),
    .i_rst_n (iRst_n),
    .i_flush (w_restart),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_rd_pix),
    .o_data  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state        <= ST_IDLE;
      r_px_cnt       <= '0;
      r_inflight     <= 1'b0;
      oValid         <= 1'b0;
      oRed           <= '0;
      oGreen         <= '0;
      oBlue          <= '0;
      oUnderflow     <= 1'b0;
      oUnderflow_cnt <= '0;
      oFrame_short   <= 1'b0;
    end else begin
      r_inflight   <= w_rd;
      oValid       <= iReq;
      oFrame_short <= w_restart && (r_state == ST_STREAM) && (r_px_cnt < LAST_PIX);

      if (iReq) {oRed, oGreen, oBlue} <= w_pop ? w_head : '0;

      if (w_stream_req && !w_pop) begin
        oUnderflow <= 1'b1;
        if (oUnderflow_cnt != 16'hFFFF) oUnderflow_cnt <= oUnderflow_cnt + 16'd1;
      end

      if (w_restart) begin
        r_state  <= ST_FILL;
        r_px_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (iFrame_start) r_state <= ST_FILL;
          ST_FILL: if (({1'b0, w_count} + {2'b00, r_inflight}) == 3'd2) r_state <= ST_STREAM;
          ST_STREAM: begin
            if (w_stream_req) begin
              if (r_px_cnt == LAST_PIX) begin
                r_state  <= ST_IDLE;
                r_px_cnt <= '0;
              end else begin
                r_px_cnt <= r_px_cnt + CNT_W'(1);
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_pixel_reader.sv
// Bench for sdram_pixel_reader: FIFO model feeding random words, scoreboard of
// expected pixels in FIFO order, and directed frame/underflow/reset scenarios.
module tb_sdram_pixel_reader;
  import sdram_pixel_reader_pkg::*;

  localparam int FP = 1024;
  localparam bit K_PIX = 1'b0;
  localparam bit K_BLACK = 1'b1;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iFrame_start = 1'b0;
  logic        iReq = 1'b0;
  logic        iRd1_empty = 1'b1;
  logic        iRd2_empty = 1'b1;
  logic [15:0] iRd1_data = '0;
  logic [15:0] iRd2_data = '0;
  logic        oRd;
  logic [9:0]  oRed;
  logic [9:0]  oGreen;
  logic [9:0]  oBlue;
  logic        oValid;
  logic        oUnderflow;
  logic [15:0] oUnderflow_cnt;
  logic        oFrame_short;
  logic [1:0]  oDbg_state;

  sdram_pixel_reader #(.FRAME_PIXELS(FP), .CNT_W(10)) dut (
    .iClk           (iClk),
    .iRst_n         (iRst_n),
    .iFrame_start   (iFrame_start),
    .iReq           (iReq),
    .iRd1_empty     (iRd1_empty),
    .iRd2_empty     (iRd2_empty),
    .iRd1_data      (iRd1_data),
    .iRd2_data      (iRd2_data),
    .oRd            (oRd),
    .oRed           (oRed),
    .oGreen         (oGreen),
    .oBlue          (oBlue),
    .oValid         (oValid),
    .oUnderflow     (oUnderflow),
    .oUnderflow_cnt (oUnderflow_cnt),
    .oFrame_short   (oFrame_short),
    .oDbg_state     (oDbg_state)
  );

  // clock / watchdog
  always #5 iClk = ~iClk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] fifo_q[$];   // {rd1_word, rd2_word}
  logic [29:0] exp_q[$];
  bit          kind_q[$];
  bit          rd_seen = 1'b0;
  bit          req_d = 1'b0;
  logic [29:0] last_pix = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] ref_pixel(input logic [31:0] w);
    logic [15:0] w1;
    logic [15:0] w2;
    w1 = w[31:16];
    w2 = w[15:0];
    return {w2[9:0], w1[14:10], w2[14:10], w1[9:0]};
  endfunction

  // FIFO model: a read strobed at this edge presents the head word just after it.
  task automatic edge_half();
    logic [31:0] w;
    @(posedge iClk);
    #1;
    req_d = iReq && iRst_n;
    if (rd_seen) begin
      check_eq("fifo_read_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        iRd1_data = w[31:16];
        iRd2_data = w[15:0];
        exp_q.push_back(ref_pixel(w));
      end
    end
    iRd1_empty = (fifo_q.size() == 0);
    iRd2_empty = (fifo_q.size() == 0);
  endtask

  // Scoreboard: every request answered next cycle, data in FIFO order or black.
  task automatic neg_half();
    logic [29:0] pix;
    bit k;
    @(negedge iClk);
    pix = {oRed, oGreen, oBlue};
    check_eq("valid", 32'(oValid), 32'(req_d));
    if (req_d) begin
      k = (kind_q.size() != 0) ? kind_q.pop_front() : K_BLACK;
      if (k == K_PIX) begin
        check_eq("exp_pixel_available", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("pixel", 32'(pix), 32'(exp_q.pop_front()));
      end else begin
        check_eq("black_pixel", 32'(pix), 32'd0);
      end
    end else begin
      check_eq("pixel_hold", 32'(pix), 32'(last_pix));
    end
    last_pix = pix;
    rd_seen = oRd;
  endtask

  task automatic step(input bit req, input bit fs, input bit kind);
    edge_half();
    iReq = req;
    iFrame_start = fs;
    if (req) kind_q.push_back(kind);
    neg_half();
  endtask

  task automatic wait_state(input logic [1:0] st, input int max, input string tag);
    int n = 0;
    while (oDbg_state != st && n < max) begin
      step(1'b0, 1'b0, K_PIX);
      n++;
    end
    check_eq(tag, 32'(oDbg_state), 32'(st));
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back($urandom());
    iRd1_empty = (fifo_q.size() == 0);
    iRd2_empty = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    @(posedge iClk);
    #1;
    iRst_n = 1'b0;
    iReq = 1'b0;
    iFrame_start = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    kind_q.delete();
    rd_seen = 1'b0;
    req_d = 1'b0;
    last_pix = '0;
    iRd1_empty = 1'b1;
    iRd2_empty = 1'b1;
    @(negedge iClk);
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    @(negedge iClk);
  endtask

  initial begin
    int  sent;
    bit  r;

    // reset values
    repeat (2) @(negedge iClk);
    check_eq("rst_rd", 32'(oRd), 32'd0);
    check_eq("rst_valid", 32'(oValid), 32'd0);
    check_eq("rst_pixel", 32'({oRed, oGreen, oBlue}), 32'd0);
    check_eq("rst_uf", 32'(oUnderflow), 32'd0);
    check_eq("rst_uf_cnt", 32'(oUnderflow_cnt), 32'd0);
    check_eq("rst_short", 32'(oFrame_short), 32'd0);
    check_eq("rst_state", 32'(oDbg_state), 32'(ST_IDLE));
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    @(negedge iClk);

    // idle: no reads even with data waiting, requests answered black
    fifo_q.push_back({16'h03FF, 16'h7C00});
    load_words(1099);
    step(1'b0, 1'b0, K_PIX);
    step(1'b0, 1'b0, K_PIX);
    check_eq("idle_no_rd", 32'(oRd), 32'd0);
    step(1'b1, 1'b0, K_BLACK);
    step(1'b0, 1'b0, K_PIX);
    check_eq("idle_req_no_uf", 32'(oUnderflow_cnt), 32'd0);

    // full frame with random request gaps
    step(1'b0, 1'b1, K_PIX);
    step(1'b0, 1'b0, K_PIX);
    check_eq("fs_state_fill", 32'(oDbg_state), 32'(ST_FILL));
    check_eq("fs_idle_no_short", 32'(oFrame_short), 32'd0);
    wait_state(ST_STREAM, 10, "fill_to_stream");
    step(1'b1, 1'b0, K_PIX);
    step(1'b0, 1'b0, K_PIX);
    check_eq("first_valid", 32'(oValid), 32'd1);
    check_eq("first_red", 32'(oRed), 32'h000);
    check_eq("first_green", 32'(oGreen), 32'h01F);
    check_eq("first_blue", 32'(oBlue), 32'h3FF);
    sent = 1;
    while (sent < FP) begin
      r = ($urandom_range(0, 9) < 7);
      step(r, 1'b0, K_PIX);
      if (r) sent++;
    end
    step(1'b0, 1'b0, K_PIX);
    check_eq("frame_end_idle", 32'(oDbg_state), 32'(ST_IDLE));
    check_eq("frame_end_cnt", 32'(dut.r_px_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, K_PIX);
      check_eq("idle_rd_low", 32'(oRd), 32'd0);
    end
    check_eq("frame_uf_flag", 32'(oUnderflow), 32'd0);
    check_eq("frame_uf_cnt", 32'(oUnderflow_cnt), 32'd0);
    step(1'b1, 1'b0, K_BLACK);
    step(1'b0, 1'b0, K_PIX);
    check_eq("post_frame_uf_cnt", 32'(oUnderflow_cnt), 32'd0);

    // short frame: restart after 5 pops, then a restart while filling
    step(1'b0, 1'b1, K_PIX);
    wait_state(ST_STREAM, 10, "refill_to_stream");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, K_PIX);
    step(1'b0, 1'b1, K_PIX);
    step(1'b0, 1'b1, K_PIX);
    check_eq("short_pulse", 32'(oFrame_short), 32'd1);
    check_eq("short_state_fill", 32'(oDbg_state), 32'(ST_FILL));
    check_eq("short_cnt_clear", 32'(dut.r_px_cnt), 32'd0);
    step(1'b0, 1'b0, K_PIX);
    check_eq("short_one_cycle", 32'(oFrame_short), 32'd0);
    check_eq("restart_in_fill", 32'(oDbg_state), 32'(ST_FILL));

    // underflow: two words available, five requests
    do_reset();
    load_words(2);
    step(1'b0, 1'b1, K_PIX);
    wait_state(ST_STREAM, 10, "uf_fill_to_stream");
    step(1'b1, 1'b0, K_PIX);
    step(1'b1, 1'b0, K_PIX);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, K_BLACK);
    step(1'b0, 1'b0, K_PIX);
    step(1'b0, 1'b0, K_PIX);
    check_eq("uf_flag", 32'(oUnderflow), 32'd1);
    check_eq("uf_cnt", 32'(oUnderflow_cnt), 32'd3);

    // asynchronous reset with a read in flight
    do_reset();
    load_words(20);
    step(1'b0, 1'b1, K_PIX);
    wait_state(ST_STREAM, 10, "ar_fill_to_stream");
    step(1'b1, 1'b0, K_PIX);
    check_eq("stream_rd_on_pop", 32'(oRd), 32'd1);
    edge_half();
    iReq = 1'b0;
    #1;
    iRst_n = 1'b0;
    #1;
    check_eq("ar_rd", 32'(oRd), 32'd0);
    check_eq("ar_valid", 32'(oValid), 32'd0);
    check_eq("ar_pixel", 32'({oRed, oGreen, oBlue}), 32'd0);
    check_eq("ar_uf", 32'(oUnderflow), 32'd0);
    check_eq("ar_uf_cnt", 32'(oUnderflow_cnt), 32'd0);
    check_eq("ar_short", 32'(oFrame_short), 32'd0);
    check_eq("ar_state", 32'(oDbg_state), 32'(ST_IDLE));
    #1;
    iRst_n = 1'b1;
    kind_q.delete();
    exp_q.delete();
    req_d = 1'b0;
    last_pix = '0;
    neg_half();
    step(1'b0, 1'b0, K_PIX);
    check_eq("ar_inflight_dropped", 32'(dut.u_buf.r_count), 32'd0);
    step(1'b0, 1'b1, K_PIX);
    wait_state(ST_STREAM, 10, "ar_refill_to_stream");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, K_PIX);
    step(1'b0, 1'b0, K_PIX);
    step(1'b0, 1'b0, K_PIX);

    check_eq("all_requests_answered", 32'(kind_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_pixel_reader.md
SDRAM_PIXEL_READER -- requirements
Module: sdram_pixel_reader

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 307200, giving the number of pixels popped per frame.
REQ-002 SHALL have parameter CNT_W, default 19, giving the pixel-counter width.
REQ-003 SHALL have port iClk, input, 1, the single clock.
REQ-004 SHALL have port iRst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port iFrame_start, input, 1, a one-cycle pulse at display vertical sync.
REQ-006 SHALL have port iReq, input, 1, the display pixel request (one pixel per asserted cycle).
REQ-007 SHALL have port iRd1_empty, input, 1, the empty flag of SDRAM read FIFO 1.
REQ-008 SHALL have port iRd2_empty, input, 1, the empty flag of SDRAM read FIFO 2.
REQ-009 SHALL have port iRd1_data, input, 16, the FIFO 1 word ({0, G[9:5], B[9:0]}), valid one cycle after oRd.
REQ-010 SHALL have port iRd2_data, input, 16, the FIFO 2 word ({0, G[4:0], R[9:0]}), valid one cycle after oRd.
REQ-011 SHALL have port oRd, output, 1, the shared read strobe to both FIFOs.
REQ-012 SHALL have port oRed, output, 10, the pixel red value.
REQ-013 SHALL have port oGreen, output, 10, the pixel green value.
REQ-014 SHALL have port oBlue, output, 10, the pixel blue value.
REQ-015 SHALL have port oValid, output, 1, qualifying oRed, oGreen and oBlue.
REQ-016 SHALL have port oUnderflow, output, 1, a sticky flag set when a request finds the buffer empty.
REQ-017 SHALL have port oUnderflow_cnt, output, 16, a saturating underflow counter.
REQ-018 SHALL have port oFrame_short, output, 1, a one-cycle pulse when iFrame_start arrives before FRAME_PIXELS pops.

Function
REQ-019 SHALL implement states IDLE, FILL and STREAM.
REQ-020 SHALL leave IDLE for FILL on iFrame_start.
REQ-021 SHALL move from FILL to STREAM when the buffer count plus in-flight reads equals 2.
REQ-022 SHALL return from STREAM to IDLE on the cycle the pixel counter reaches FRAME_PIXELS-1 with a pop.
REQ-023 SHALL, when iFrame_start occurs in FILL or STREAM, pulse oFrame_short only if in STREAM with the counter below FRAME_PIXELS-1, clear the counter, flush the buffer, drop in-flight data and enter FILL.
REQ-024 SHALL provide a 2-entry 30-bit pixel buffer that holds unpacked RGB.
REQ-025 SHALL assert oRd only in FILL or STREAM, only when both empty flags are low, and only when buffer occupancy plus in-flight reads is below 2, counting a same-cycle pop as freeing an entry.
REQ-026 SHALL allow at most one read in flight.
REQ-027 SHALL write the returned data into the buffer on the cycle after oRd.
REQ-028 SHALL unpack as Red=iRd2_data[9:0], Green={iRd1_data[14:10], iRd2_data[14:10]}, Blue=iRd1_data[9:0], ignoring bit 15 of each word.
REQ-029 SHALL, for iReq in STREAM with a non-empty buffer, present the oldest entry on oRed, oGreen and oBlue with oValid=1 on the next cycle, and increment the pixel counter.
REQ-030 SHALL, for iReq in STREAM with an empty buffer (including a same-cycle write), output 0/0/0 with oValid=1 next cycle, set oUnderflow, increment oUnderflow_cnt saturating at 16'hFFFF, and still increment the pixel counter.
REQ-031 SHALL, for iReq in IDLE or FILL, output 0/0/0 with oValid=1 next cycle, without counting a pixel or an underflow.
REQ-032 SHALL hold oValid=0 and hold the pixel outputs at their previous values when iReq=0.
REQ-033 SHALL, when a write and a pop fall on the same cycle with occupancy 1, pop the old entry and retain the new one; with occupancy 0 the case is an underflow per REQ-030.
REQ-034 SHALL clear oUnderflow and oUnderflow_cnt only by reset.

Reset
REQ-035 SHALL, while iRst_n=0, asynchronously force state IDLE, buffer empty, in-flight flag 0, counter 0, oRd=0, oValid=0, oRed/oGreen/oBlue=0, oUnderflow=0, oUnderflow_cnt=0 and oFrame_short=0.
REQ-036 SHALL discard any read in flight at reset; FIFO flushing is the SDRAM controller's responsibility.

Structure
REQ-037 SHALL place the packing bit-field constants (R, G-high, G-low, B positions) and the state encoding in the shared video package, common with the writer-side packer.
REQ-038 SHALL implement the 2-entry buffer as sub-module pixel_skid_buf2 (push, pop, data, count).

Verification
REQ-039 SHALL cover: reset, frame_start, FIFOs non-empty with iRd1=16'h03FF and iRd2=16'h7C00, then iReq -> next cycle oValid=1, R=0, G=10'h01F, B=10'h3FF.
REQ-040 SHALL cover: FIFOs empty in STREAM with iReq held 3 cycles -> three black pixels, oUnderflow=1, oUnderflow_cnt=3.
REQ-041 SHALL cover: FRAME_PIXELS=4, FIFOs always full, iReq for 4 cycles -> state IDLE after 4th pop, oRd=0 thereafter.
REQ-042 SHALL cover: FRAME_PIXELS=8, frame_start after 5 pops -> oFrame_short one-cycle pulse, counter 0, FILL.
REQ-043 SHALL cover: continuous iReq with FIFOs always non-empty for 1000 cycles -> zero underflows and pixel order matching FIFO order.
REQ-044 SHALL cover: iRst_n asserted mid-STREAM with a read in flight -> all outputs 0 immediately (asynchronous) and the returned word not written to the buffer.
